vcrtc: RTL and testbench

CPU-facing video controller register block for the 8088 system. It decodes the CGA I/O ports 3D4h/3D5h/3D8h/3D9h/3DAh and holds the 6845-style CRTC registers. It drives the cursor position, start address and mode bits into the display generator `vcard`. It also synchronises `vcard`'s sync outputs back into the 3DAh status register.

---
 rtl/vcrtc_pkg.sv | 26 ++
 rtl/vcrtc_sync.sv | 44 ++++
 rtl/vcrtc.sv | 159 +++++++++++++++
 tb/tb_vcrtc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcrtc_pkg.sv
// vcrtc_pkg: shared constants for the CGA/6845-style register block.
//   Port offsets within the 3Dxh block, CRTC register indices used by
//   the block, the cursor-off sentinel and reset constants.
package vcrtc_pkg;

  localparam logic [3:0] P_INDEX  = 4'h4;
  localparam logic [3:0] P_DATA   = 4'h5;
  localparam logic [3:0] P_MODE   = 4'h8;
  localparam logic [3:0] P_COLOR  = 4'h9;
  localparam logic [3:0] P_STATUS = 4'hA;

  localparam logic [4:0] R_CUR_START = 5'd10;
  localparam logic [4:0] R_CUR_END   = 5'd11;
  localparam logic [4:0] R_START_HI  = 5'd12;
  localparam logic [4:0] R_START_LO  = 5'd13;
  localparam logic [4:0] R_CUR_HI    = 5'd14;
  localparam logic [4:0] R_CUR_LO    = 5'd15;

  // Beyond the 2000 text cells, so the display never matches it.
  localparam logic [10:0] CURSOR_OFF = 11'h7FF;

  localparam logic [7:0] IO_OUT_RST  = 8'hFF;
  localparam logic       WR_PREV_RST = 1'b1;
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/vcrtc_sync.sv
// vcrtc_sync: two-flop synchroniser with optional rising-edge detect.
//   clock, reset_n : clock and async active-low reset
//   d              : asynchronous input
//   q              : synchronised level (2 clocks of latency)
//   rise           : one-cycle high on a 0->1 of q (EDGE_EN=1), else 0
module vcrtc_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (EDGE_EN) begin : g_edge
      logic s3;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) s3 <= 1'b0;
        else          s3 <= s2;
      end
      assign rise = s2 & ~s3;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/vcrtc.sv
// vcrtc: CPU-facing CGA video register block (3D4h/3D5h/3D8h/3D9h/3DAh).
//   clock, reset_n       : clock and async active-low reset
//   io_address/io_in     : CPU port address and write data
//   io_write             : write strobe, acted on at its rising edge only
//   io_read              : read qualifier (reads have no side effects)
//   io_out               : registered read data, 1 cycle latency
//   hs (neg), vs (pos)   : sync outputs of vcard, synchronised into 3DAh
//   cga, video_en        : mode bits 1 and 3
//   cursor, start_addr   : cursor cell and display start to vcard
//   color_sel            : 3D9h contents
//   irq                  : vertical-retrace pulse
// Optional feature macro: VCRTC_VSYNC_IRQ_EN enables irq (gated by video_en);
// otherwise irq is tied low.
module vcrtc
  import vcrtc_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h03D0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] io_address,
  input  logic        io_write,
  input  logic        io_read,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  input  logic        hs,
  input  logic        vs,
  output logic        cga,
  output logic        video_en,
  output logic [10:0] cursor,
  output logic [13:0] start_addr,
  output logic [7:0]  color_sel,
  output logic        irq
);

  logic       wr_prev;
  logic       wr_fire;
  logic [4:0] index;
  logic [6:0] r10;
  logic [6:0] r11;
  logic [5:0] r12;
  logic [7:0] r13;
  logic [5:0] r14;
  logic [7:0] r15;
  logic [5:0] mode;
  logic       vr;
  logic       hr;
  logic       vr_rise;
  logic       hr_rise;

  logic sel_index, sel_data, sel_mode, sel_color, sel_status;

  assign sel_index  = (io_address == BASE + {12'h000, P_INDEX});
  assign sel_data   = (io_address == BASE + {12'h000, P_DATA});
  assign sel_mode   = (io_address == BASE + {12'h000, P_MODE});
  assign sel_color  = (io_address == BASE + {12'h000, P_COLOR});
  assign sel_status = (io_address == BASE + {12'h000, P_STATUS});

  // wr_prev resets high so a strobe held through reset release is not a write.
  assign wr_fire = io_write & ~wr_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev   <= WR_PREV_RST;
      index     <= '0;
      r10       <= '0;
      r11       <= '0;
      r12       <= '0;
      r13       <= '0;
      r14       <= '0;
      r15       <= '0;
      mode      <= '0;
      color_sel <= '0;
    end else begin
      wr_prev <= io_write;
      if (wr_fire) begin
        if (sel_index) index <= io_in[4:0];
        if (sel_mode)  mode <= io_in[5:0];
        if (sel_color) color_sel <= io_in;
        if (sel_data) begin
          case (index)
            R_CUR_START: r10 <= io_in[6:0];
            R_CUR_END:   r11 <= io_in[6:0];
            R_START_HI:  r12 <= io_in[5:0];
            R_START_LO:  r13 <= io_in;
            R_CUR_HI:    r14 <= io_in[5:0];
            R_CUR_LO:    r15 <= io_in;
            default:     ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_out <= IO_OUT_RST;
    end else if (sel_index) begin
      io_out <= {3'b000, index};
    end else if (sel_data) begin
      if (index == R_CUR_HI)      io_out <= {2'b00, r14};
      else if (index == R_CUR_LO) io_out <= r15;
      else                        io_out <= 8'h00;
    end else if (sel_mode) begin
      io_out <= {2'b00, mode};
    end else if (sel_color) begin
      io_out <= color_sel;
    end else if (sel_status) begin
      io_out <= {4'hF, vr, 2'b00, vr | hr};
    end else begin
      io_out <= UNMAPPED_RD;
    end
  end

  assign cga        = mode[1];
  assign video_en   = mode[3];
  assign start_addr = {r12, r13};
  // R10[6:5] = 01 is the 6845 "cursor off" blink mode.
  assign cursor     = (r10[6:5] == 2'b01) ? CURSOR_OFF : {r14[2:0], r15};

`ifdef VCRTC_VSYNC_IRQ_EN
  localparam bit VR_EDGE = 1'b1;
`else
  localparam bit VR_EDGE = 1'b0;
`endif

  vcrtc_sync #(.EDGE_EN(VR_EDGE)) u_sync_vs (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (vs),
    .q       (vr),
    .rise    (vr_rise)
  );

  vcrtc_sync #(.EDGE_EN(1'b0)) u_sync_hs (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (~hs),
    .q       (hr),
    .rise    (hr_rise)
  );

`ifdef VCRTC_VSYNC_IRQ_EN
  // Registered so the pulse lands 3 clocks after vs rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= vr_rise & mode[3];
  end

  logic unused_bits;
  assign unused_bits = ^{io_read, r10[4:0], r11, r14[5:3], hr_rise};
`else
  assign irq = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{io_read, r10[4:0], r11, r14[5:3], hr_rise, vr_rise};
`endif

endmodule

// File: tb/tb_vcrtc.sv
module tb_vcrtc;

`ifdef VCRTC_VSYNC_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] io_address;
  logic        io_write;
  logic        io_read;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic        hs;
  logic        vs;
  logic        cga;
  logic        video_en;
  logic [10:0] cursor;
  logic [13:0] start_addr;
  logic [7:0]  color_sel;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [4:0] m_index;
  logic [7:0] m_r [10:15];
  logic [5:0] m_mode;
  logic [7:0] m_color;

  vcrtc dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .io_address (io_address),
    .io_write   (io_write),
    .io_read    (io_read),
    .io_in      (io_in),
    .io_out     (io_out),
    .hs         (hs),
    .vs         (vs),
    .cga        (cga),
    .video_en   (video_en),
    .cursor     (cursor),
    .start_addr (start_addr),
    .color_sel  (color_sel),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_index = 0;
    for (int i = 10; i <= 15; i++) m_r[i] = 8'h00;
    m_mode  = 0;
    m_color = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    case (a)
      16'h03D4: m_index = d[4:0];
      16'h03D5: begin
        if (m_index == 10 || m_index == 11)      m_r[m_index] = d & 8'h7F;
        else if (m_index == 12 || m_index == 14) m_r[m_index] = d & 8'h3F;
        else if (m_index == 13 || m_index == 15) m_r[m_index] = d;
      end
      16'h03D8: m_mode = d[5:0];
      16'h03D9: m_color = d;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] a, input logic [7:0] status);
    case (a)
      16'h03D4: return {3'b000, m_index};
      16'h03D5: return (m_index == 14) ? m_r[14] : (m_index == 15) ? m_r[15] : 8'h00;
      16'h03D8: return {2'b00, m_mode};
      16'h03D9: return m_color;
      16'h03DA: return status;
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic logic [10:0] exp_cursor();
    logic [7:0] r10;
    r10 = m_r[10];
    if (r10[6:5] == 2'b01) return 11'h7FF;
    return (11'(m_r[14] & 8'h07) << 8) | 11'(m_r[15]);
  endfunction

  function automatic logic [13:0] exp_start();
    return (14'(m_r[12]) << 8) | 14'(m_r[13]);
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    io_address = a;
    io_in      = d;
    io_write   = 1'b1;
    tick();
    model_write(a, d);
    io_write = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    io_address = a;
    tick();
    d = io_out;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; io_write = 1'b0; io_read = 1'b0; io_in = 0;
    io_address = 16'h0000; hs = 1'b1; vs = 1'b0;
    model_reset();
    #12;
    checks++; if (io_out !== 8'hFF) begin errors++; $display("FAIL reset_io_out got=%h exp=FF", io_out); end
    checks++; if ({cga, video_en, irq} !== 3'b000) begin errors++; $display("FAIL reset_bits got=%b exp=000", {cga, video_en, irq}); end
    checks++; if (cursor !== 11'h000 || start_addr !== 14'h0) begin errors++; $display("FAIL reset_addr cursor=%h start=%h exp=0", cursor, start_addr); end
    checks++; if (color_sel !== 8'h00) begin errors++; $display("FAIL reset_color got=%h exp=00", color_sel); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cursor();
    logic [7:0] d;
    wr(16'h03D4, 8'h0E); wr(16'h03D5, 8'h03);
    wr(16'h03D4, 8'h0F); wr(16'h03D5, 8'hE8);
    checks++; if (cursor !== 11'h3E8) begin errors++; $display("FAIL cursor_write got=%h exp=3E8", cursor); end
    rd(16'h03D5, d);
    checks++; if (d !== 8'hE8) begin errors++; $display("FAIL cursor_readback got=%h exp=E8", d); end
    wr(16'h03D4, 8'h0E);
    rd(16'h03D5, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL r14_readback got=%h exp=03", d); end
  endtask

  task automatic test_cursor_disable();
    wr(16'h03D4, 8'h0A); wr(16'h03D5, 8'h20);
    checks++; if (cursor !== 11'h7FF) begin errors++; $display("FAIL cursor_off got=%h exp=7FF", cursor); end
    wr(16'h03D5, 8'h06);
    checks++; if (cursor !== 11'h3E8) begin errors++; $display("FAIL cursor_on got=%h exp=3E8", cursor); end
    wr(16'h03D5, 8'h60);
    checks++; if (cursor !== 11'h3E8) begin errors++; $display("FAIL cursor_blink11 got=%h exp=3E8", cursor); end
    wr(16'h03D5, 8'h00);
  endtask

  task automatic test_mode();
    wr(16'h03D8, 8'h0A);
    checks++; if ({cga, video_en} !== 2'b11) begin errors++; $display("FAIL mode_0a got=%b exp=11", {cga, video_en}); end
    wr(16'h03D8, 8'h29);
    checks++; if ({cga, video_en} !== 2'b01) begin errors++; $display("FAIL mode_29 got=%b exp=01", {cga, video_en}); end
  endtask

  task automatic test_back_to_back();
    wr(16'h03D4, 8'h0F);
    io_address = 16'h03D5; io_in = 8'h5A; io_write = 1'b1;
    tick();
    model_write(16'h03D5, 8'h5A);
    io_write = 1'b0;
    tick();
    checks++; if (io_out !== 8'h5A) begin errors++; $display("FAIL b2b_read got=%h exp=5A", io_out); end
    wr(16'h03D4, 8'h15);
    rd(16'h03D4, io_in);
    checks++; if (io_in !== 8'h15) begin errors++; $display("FAIL index_hi_read got=%h exp=15", io_in); end
  endtask

  task automatic test_status();
    logic [7:0] d;
    io_address = 16'h03DA; vs = 1'b1;
    tick(); tick();
    checks++; if (io_out !== 8'hF0) begin errors++; $display("FAIL status_early got=%h exp=F0", io_out); end
    tick();
    checks++; if (io_out !== 8'hF9) begin errors++; $display("FAIL status_vs got=%h exp=F9", io_out); end
    vs = 1'b0; hs = 1'b0;
    repeat (4) tick();
    rd(16'h03DA, d);
    checks++; if (d !== 8'hF1) begin errors++; $display("FAIL status_hs got=%h exp=F1", d); end
    hs = 1'b1;
    repeat (4) tick();
    rd(16'h03DA, d);
    checks++; if (d !== 8'hF0) begin errors++; $display("FAIL status_idle got=%h exp=F0", d); end
  endtask

  task automatic test_irq();
    logic [3:0] seen;
    int extra;
    wr(16'h03D8, 8'h08);
    vs = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); seen[i] = irq; end
    checks++; if (seen !== (IRQ_ON ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL irq_pulse got=%b exp=%b", seen, IRQ_ON ? 4'b0100 : 4'b0000); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (irq) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL irq_once got=%0d exp=0", extra); end
    vs = 1'b0;
    repeat (4) tick();
    wr(16'h03D8, 8'h00);
    vs = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (irq) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL irq_gated got=%0d exp=0", extra); end
    vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    rd(16'h03BC, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmapped_3bc got=%h exp=FF", d); end
    rd(16'h13D4, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL unmapped_13d4 got=%h exp=FF", d); end
  endtask

  task automatic test_random();
    logic [15:0] ports [6];
    logic [15:0] a;
    logic [7:0]  d, got;
    ports[0] = 16'h03D4; ports[1] = 16'h03D5; ports[2] = 16'h03D8;
    ports[3] = 16'h03D9; ports[4] = 16'h03DA; ports[5] = 16'h03B5;
    for (int n = 0; n < 60; n++) begin
      a = ports[$urandom_range(0, 5)];
      d = 8'($urandom);
      if (a == 16'h03D4 && ($urandom_range(0, 3) != 0)) d = 8'($urandom_range(8, 17));
      if (a == 16'h03D5 && ($urandom_range(0, 1) == 0)) wr(16'h03D4, 8'($urandom_range(10, 15)));
      wr(a, d);
      checks++; if (cursor !== exp_cursor()) begin errors++; $display("FAIL rnd_cursor n=%0d got=%h exp=%h", n, cursor, exp_cursor()); end
      checks++; if (start_addr !== exp_start()) begin errors++; $display("FAIL rnd_start n=%0d got=%h exp=%h", n, start_addr, exp_start()); end
      checks++; if ({cga, video_en, color_sel} !== {m_mode[1], m_mode[3], m_color}) begin
        errors++; $display("FAIL rnd_mode n=%0d got=%b%b/%h exp=%b%b/%h", n, cga, video_en, color_sel, m_mode[1], m_mode[3], m_color);
      end
      a = ports[$urandom_range(0, 5)];
      rd(a, got);
      checks++; if (got !== exp_read(a, 8'hF0)) begin errors++; $display("FAIL rnd_read n=%0d addr=%h got=%h exp=%h", n, a, got, exp_read(a, 8'hF0)); end
    end
  endtask

  task automatic test_held_strobe();
    wr(16'h03D9, 8'h00);
    io_address = 16'h03D9; io_in = 8'h11; io_write = 1'b1;
    tick();
    io_in = 8'h22;
    repeat (9) tick();
    checks++; if (color_sel !== 8'h11) begin errors++; $display("FAIL held_single got=%h exp=11", color_sel); end
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++; if (color_sel !== 8'h00) begin errors++; $display("FAIL async_reset got=%h exp=00", color_sel); end
    tick(); tick();
    reset_n = 1'b1; io_in = 8'h33;
    repeat (4) tick();
    checks++; if (color_sel !== 8'h00) begin errors++; $display("FAIL held_through_reset got=%h exp=00", color_sel); end
    io_write = 1'b0;
    tick();
    wr(16'h03D9, 8'h44);
    checks++; if (color_sel !== 8'h44) begin errors++; $display("FAIL after_release got=%h exp=44", color_sel); end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_cursor_disable();
    test_mode();
    test_back_to_back();
    test_status();
    test_irq();
    test_unmapped();
    test_random();
    test_held_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
